// File: rtl/gfx_pkg.sv
`timescale 1ns/1ps
// gfx_pkg -- shared definitions for the MVP sequencer slice.
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   FLOAT_ONE           : IEEE-754 single 1.0
//   state_t             : sequencer FSM state encoding
package gfx_pkg;

    localparam int          SCREEN_W  = 640;
    localparam int          SCREEN_H  = 480;
    localparam logic [31:0] FLOAT_ONE = 32'h3f800000;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_MVP_START  = 4'd1,
        ST_MVP_WAIT   = 4'd2,
        ST_FETCH      = 4'd3,
        ST_FETCH_WAIT = 4'd4,
        ST_XF_START   = 4'd5,
        ST_XF_WAIT    = 4'd6,
        ST_STORE      = 4'd7,
        ST_EMIT       = 4'd8,
        ST_DONE       = 4'd9
    } state_t;

endpackage

// File: rtl/screen_clip.sv
`timescale 1ns/1ps
// screen_clip -- combinational visibility test of one screen-space point.
//   ox, oy  : signed 32-bit integer screen coordinates
//   visible : 1 when 0 <= ox < SCREEN_W and 0 <= oy < SCREEN_H
module screen_clip
    import gfx_pkg::*;
(
    input  logic signed [31:0] ox,
    input  logic signed [31:0] oy,
    output logic               visible
);

    assign visible = (ox >= 0) && (ox <= SCREEN_W - 1) &&
                     (oy >= 0) && (oy <= SCREEN_H - 1);

endmodule

// File: rtl/mvp_sequencer.sv
`timescale 1ns/1ps
// mvp_sequencer -- walks a vertex list in pairs, sends each vertex through
// an external transform unit, clips the resulting line and emits it.
//   clock, resetn            : rising-edge clock, synchronous active-low reset
//   frame_start              : one-cycle frame request (ignored while busy)
//   update_mvp_req           : rebuild MVP matrix before the frame
//   num_verts                : vertex count, sampled with frame_start
//   vert_addr / vert_data    : vertex memory port (data one cycle after addr)
//   xf_start, xf_update_mvp  : transform unit start pulse and mode
//   xf_x, xf_y, xf_z         : vertex handed to the transform unit
//   xf_done, xf_ox, xf_oy    : transform unit idle flag and screen result
//   line_valid / line_ready  : line output handshake, endpoints x0,y0,x1,y1
//   frame_done               : one-cycle end-of-frame pulse
//   busy                     : high outside IDLE
//   drop_count               : lines rejected by clipping this frame
module mvp_sequencer
    import gfx_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                frame_start,
    input  logic                update_mvp_req,
    input  logic [ADDR_W:0]     num_verts,
    output logic [ADDR_W-1:0]   vert_addr,
    input  logic [95:0]         vert_data,
    output logic                xf_start,
    output logic                xf_update_mvp,
    output logic [31:0]         xf_x,
    output logic [31:0]         xf_y,
    output logic [31:0]         xf_z,
    input  logic                xf_done,
    input  logic signed [31:0]  xf_ox,
    input  logic signed [31:0]  xf_oy,
    output logic                line_valid,
    input  logic                line_ready,
    output logic [9:0]          x0,
    output logic [8:0]          y0,
    output logic [9:0]          x1,
    output logic [8:0]          y1,
    output logic                frame_done,
    output logic                busy,
    output logic [15:0]         drop_count
);

    localparam int CW = ADDR_W + 2;

    state_t                 state;
    logic [ADDR_W:0]        nverts;
    logic [ADDR_W:0]        idx;
    logic signed [31:0]     p0_ox;
    logic signed [31:0]     p0_oy;
    logic                   p0_vis;
    logic                   p1_vis;
    logic [CW-1:0]          idx_w;
    logic [CW-1:0]          nv_w;
    logic                   last_at_store;
    logic                   last_at_emit;
    logic                   few_verts;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // P0 is held from the even STORE; P1 is tested live on the odd STORE.
    screen_clip u_clip_p0 (.ox(p0_ox), .oy(p0_oy), .visible(p0_vis));
    screen_clip u_clip_p1 (.ox(xf_ox), .oy(xf_oy), .visible(p1_vis));

    // Widened by one bit so index+2 never wraps against num_verts.
    assign idx_w = {1'b0, idx};
    assign nv_w  = {1'b0, nverts};
    // In STORE idx is the odd index i; in EMIT it has already advanced to i+1.
    // Either way the frame ends once no complete pair remains after i.
    assign last_at_store = (idx_w + CW'(2)) >= nv_w;
    assign last_at_emit  = (idx_w + CW'(1)) >= nv_w;
    assign few_verts     = nverts < (ADDR_W+1)'(2);

    assign busy          = (state != ST_IDLE);
    assign xf_start      = (state == ST_MVP_START) || (state == ST_XF_START);
    assign xf_update_mvp = (state == ST_MVP_START);
    assign line_valid    = (state == ST_EMIT);
    assign frame_done    = (state == ST_DONE);
    assign vert_addr     = idx[ADDR_W-1:0];
    assign x0            = p0_ox[9:0];
    assign y0            = p0_oy[8:0];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            nverts     <= '0;
            idx        <= '0;
            drop_count <= '0;
            xf_x       <= '0;
            xf_y       <= '0;
            xf_z       <= '0;
            p0_ox      <= '0;
            p0_oy      <= '0;
            x1         <= '0;
            y1         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        nverts     <= num_verts;
                        idx        <= '0;
                        drop_count <= '0;
                        if (update_mvp_req)
                            state <= ST_MVP_START;
                        else if (num_verts < (ADDR_W+1)'(2))
                            state <= ST_DONE;
                        else
                            state <= ST_FETCH;
                    end
                end
                ST_MVP_START: state <= ST_MVP_WAIT;
                ST_MVP_WAIT: begin
                    if (xf_done)
                        state <= few_verts ? ST_DONE : ST_FETCH;
                end
                ST_FETCH: state <= ST_FETCH_WAIT;
                ST_FETCH_WAIT: begin
                    xf_x  <= vert_data[95:64];
                    xf_y  <= vert_data[63:32];
                    xf_z  <= vert_data[31:0];
                    state <= ST_XF_START;
                end
                ST_XF_START: state <= ST_XF_WAIT;
                ST_XF_WAIT: begin
                    if (xf_done)
                        state <= ST_STORE;
                end
                ST_STORE: begin
                    idx <= idx + 1'b1;
                    if (!idx[0]) begin
                        p0_ox <= xf_ox;
                        p0_oy <= xf_oy;
                        state <= ST_FETCH;
                    end else begin
                        x1 <= xf_ox[9:0];
                        y1 <= xf_oy[8:0];
                        if (p0_vis && p1_vis) begin
                            state <= ST_EMIT;
                        end else begin
                            drop_count <= sat_inc16(drop_count);
                            state      <= last_at_store ? ST_DONE : ST_FETCH;
                        end
                    end
                end
                ST_EMIT: begin
                    if (line_ready)
                        state <= last_at_emit ? ST_DONE : ST_FETCH;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvp_sequencer.sv
`timescale 1ns/1ps
// tb_mvp_sequencer -- scoreboard bench for mvp_sequencer with a behavioural
// vertex memory and transform unit model.
module tb_mvp_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        frame_start;
    logic        update_mvp_req;
    logic [8:0]  num_verts;
    logic [7:0]  vert_addr;
    logic [95:0] vert_data;
    logic        xf_start, xf_update_mvp;
    logic [31:0] xf_x, xf_y, xf_z;
    logic        xf_done;
    logic signed [31:0] xf_ox, xf_oy;
    logic        line_valid, line_ready;
    logic [9:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic        frame_done, busy;
    logic [15:0] drop_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [95:0] mem [0:255];
    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];
    logic [31:0] xs_q[$];
    int n_xs = 0, n_mvp = 0, n_fd = 0;
    int xf_cnt = 0;

    always #5 clock = ~clock;

    mvp_sequencer #(.ADDR_W(8)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .update_mvp_req(update_mvp_req), .num_verts(num_verts),
        .vert_addr(vert_addr), .vert_data(vert_data),
        .xf_start(xf_start), .xf_update_mvp(xf_update_mvp),
        .xf_x(xf_x), .xf_y(xf_y), .xf_z(xf_z),
        .xf_done(xf_done), .xf_ox(xf_ox), .xf_oy(xf_oy),
        .line_valid(line_valid), .line_ready(line_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .frame_done(frame_done), .busy(busy), .drop_count(drop_count)
    );

    // Integer part of an IEEE-754 single (truncation toward zero).
    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        int v;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 0;
        m = {8'd0, 1'b1, f[22:0]};
        if (e >= 23) v = int'(m << (e - 23));
        else         v = int'(m >> (23 - e));
        return f[31] ? -v : v;
    endfunction

    function automatic logic [95:0] vtx(input logic [31:0] x, input logic [31:0] y);
        return {x, y, 32'h0};
    endfunction

    // Vertex memory: registered read.
    always @(posedge clock) vert_data <= mem[vert_addr];

    // Transform unit model.
    initial begin
        xf_done = 1'b1;
        xf_ox = 0;
        xf_oy = 0;
    end
    always @(posedge clock) begin
        if (xf_start) begin
            xf_done <= 1'b0;
            xf_cnt  <= 20;
            if (!xf_update_mvp) begin
                xf_ox <= f2i(xf_x) + 320;
                xf_oy <= f2i(xf_y) + 240;
            end
        end else if (xf_cnt > 0) begin
            xf_cnt <= xf_cnt - 1;
            if (xf_cnt == 1) xf_done <= 1'b1;
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (xf_start === 1'b1) begin
            n_xs++;
            if (xf_update_mvp === 1'b1) n_mvp++;
            else xs_q.push_back(xf_x);
        end
        if (line_valid === 1'b1 && line_ready === 1'b1)
            got_q.push_back({x0, y0, x1, y1});
        if (frame_done === 1'b1) n_fd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference walk of the vertex list: expected lines and drop count.
    task automatic plan_frame(input int nv, output int drops);
        int ax, ay, bx, by;
        drops = 0;
        for (int i = 0; i + 1 < nv; i += 2) begin
            ax = f2i(mem[i][95:64]) + 320;
            ay = f2i(mem[i][63:32]) + 240;
            bx = f2i(mem[i+1][95:64]) + 320;
            by = f2i(mem[i+1][63:32]) + 240;
            if (ax >= 0 && ax < 640 && ay >= 0 && ay < 480 &&
                bx >= 0 && bx < 640 && by >= 0 && by < 480)
                exp_q.push_back({ax[9:0], ay[8:0], bx[9:0], by[8:0]});
            else
                drops++;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        xs_q.delete();
    endtask

    task automatic start_frame(input logic upd, input int nv);
        @(posedge clock); #1;
        frame_start = 1'b1;
        update_mvp_req = upd;
        num_verts = nv[8:0];
        @(posedge clock); #1;
        frame_start = 1'b0;
        update_mvp_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        frame_start = 1'b0;
        update_mvp_req = 1'b0;
        num_verts = '0;
        line_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({busy, line_valid, frame_done, xf_start, xf_update_mvp} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {busy, line_valid, frame_done, xf_start, xf_update_mvp});
        end
        tests_run++;
        if (drop_count !== 16'd0 || vert_addr !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt drop=%h addr=%h want 0", drop_count, vert_addr);
        end
        tests_run++;
        if ({xf_x, xf_y, xf_z, x0, y0, x1, y1} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data xf=%h/%h/%h ln=%0d,%0d,%0d,%0d want 0",
                     xf_x, xf_y, xf_z, x0, y0, x1, y1);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_single_line();
        int drops, lat, s_fd;
        logic ok;
        logic [37:0] g, e;
        clear_sb();
        mem[0] = vtx(32'h00000000, 32'h00000000);
        mem[1] = vtx(32'h41200000, 32'h40a00000);
        plan_frame(2, drops);
        s_fd = n_fd;
        @(posedge clock); #1;
        frame_start = 1'b1;
        num_verts = 9'd2;
        update_mvp_req = 1'b0;
        @(posedge clock); #1;
        frame_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (xf_start === 1'b1) begin
                lat = c;
                break;
            end
        end
        tests_run++;
        if (lat != 3) begin
            tests_failed++;
            $display("FAIL latency got=%0d cycles want=3", lat);
        end
        wait_done(300, ok);
        tests_run++;
        if (!ok || n_fd - s_fd != 1) begin
            tests_failed++;
            $display("FAIL single_done ok=%0d frames=%0d want 1", ok, n_fd - s_fd);
        end
        tests_run++;
        if (got_q.size() != 1 || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL single_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        if (got_q.size() > 0) begin
            g = got_q[0];
            tests_run++;
            if (g !== {10'd320, 9'd240, 10'd330, 9'd245}) begin
                tests_failed++;
                $display("FAIL single_line got=%0d,%0d->%0d,%0d want 320,240->330,245",
                         g[37:28], g[27:19], g[18:9], g[8:0]);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL single_sb got=%h want=%h", g, e);
            end
        end
        tests_run++;
        if (drop_count !== drops[15:0] || busy !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_post drop=%0d busy=%b fd=%b want %0d,0,0",
                     drop_count, busy, frame_done, drops);
        end
    endtask

    task automatic test_mvp_only();
        int s_xs, s_mvp, s_fd;
        logic ok;
        clear_sb();
        s_xs = n_xs; s_mvp = n_mvp; s_fd = n_fd;
        start_frame(1'b1, 0);
        wait_done(200, ok);
        tests_run++;
        if (!ok || n_xs - s_xs != 1 || n_mvp - s_mvp != 1) begin
            tests_failed++;
            $display("FAIL mvp_only ok=%0d starts=%0d mvp=%0d want 1,1,1",
                     ok, n_xs - s_xs, n_mvp - s_mvp);
        end
        tests_run++;
        if (got_q.size() != 0 || n_fd - s_fd != 1) begin
            tests_failed++;
            $display("FAIL mvp_only_lines lines=%0d frames=%0d want 0,1",
                     got_q.size(), n_fd - s_fd);
        end
    endtask

    task automatic test_short_frame();
        int s_xs, s_fd;
        logic ok;
        clear_sb();
        s_xs = n_xs; s_fd = n_fd;
        start_frame(1'b0, 1);
        wait_done(4, ok);
        tests_run++;
        if (!ok || n_xs - s_xs != 0 || n_fd - s_fd != 1) begin
            tests_failed++;
            $display("FAIL short_frame ok=%0d starts=%0d frames=%0d want 1,0,1",
                     ok, n_xs - s_xs, n_fd - s_fd);
        end
    endtask

    task automatic test_clip();
        int drops;
        logic ok;
        logic [37:0] g, e;
        clear_sb();
        mem[0] = vtx(32'h3f800000, 32'h3f800000);   // (1,1)
        mem[1] = vtx(32'h43c80000, 32'h00000000);   // (400,0) -> ox 720
        mem[2] = vtx(32'hbf800000, 32'h40000000);   // (-1,2)
        mem[3] = vtx(32'h41a00000, 32'h40e00000);   // (20,7)
        plan_frame(4, drops);
        start_frame(1'b0, 4);
        wait_done(500, ok);
        tests_run++;
        if (!ok || drop_count !== 16'd1 || drop_count !== drops[15:0]) begin
            tests_failed++;
            $display("FAIL clip_drop ok=%0d got=%0d want=1", ok, drop_count);
        end
        tests_run++;
        if (got_q.size() != 1 || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL clip_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL clip_line got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int drops, bad;
        logic ok, seen;
        logic [37:0] hold, g, e;
        clear_sb();
        mem[0] = vtx(32'h40400000, 32'hbf800000);   // (3,-1)
        mem[1] = vtx(32'h41a00000, 32'h40e00000);   // (20,7)
        plan_frame(2, drops);
        line_ready = 1'b0;
        start_frame(1'b0, 2);
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (line_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL bp_valid got=0 want line_valid within 300 cycles");
        end
        hold = {x0, y0, x1, y1};
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (line_valid !== 1'b1 || {x0, y0, x1, y1} !== hold) bad++;
        end
        tests_run++;
        if (bad != 0 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_stable unstable_cycles=%0d transfers=%0d want 0,0",
                     bad, got_q.size());
        end
        @(posedge clock); #1;
        line_ready = 1'b1;
        wait_done(50, ok);
        tests_run++;
        if (!ok || got_q.size() != 1 || line_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release ok=%0d transfers=%0d lv=%b want 1,1,0",
                     ok, got_q.size(), line_valid);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL bp_line got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int drops, c;
        logic ok;
        logic [37:0] g, e;
        clear_sb();
        mem[0] = vtx(32'h00000000, 32'h00000000);
        mem[1] = vtx(32'h41200000, 32'h40a00000);
        start_frame(1'b0, 2);
        c = 0;
        while (xf_start !== 1'b1 && c < 20) begin
            @(negedge clock);
            c++;
        end
        repeat (5) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({busy, line_valid, frame_done, xf_start, xf_update_mvp} !== 5'b0 ||
            drop_count !== 16'd0 || vert_addr !== 8'd0 ||
            {xf_x, xf_y, xf_z, x0, y0, x1, y1} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset busy=%b lv=%b fd=%b xs=%b drop=%0d addr=%0d xf_x=%h want all 0",
                     busy, line_valid, frame_done, xf_start, drop_count, vert_addr, xf_x);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        clear_sb();
        plan_frame(2, drops);
        start_frame(1'b0, 2);
        wait_done(300, ok);
        tests_run++;
        if (!ok || got_q.size() != 1 || got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL mid_reset_rerun ok=%0d lines=%0d want 1,%0d",
                     ok, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL mid_reset_line got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_odd_ignore();
        int drops, s_mvp, s_fd;
        logic ok;
        logic [37:0] g, e;
        clear_sb();
        mem[0] = vtx(32'h40000000, 32'h40400000);   // (2,3)
        mem[1] = vtx(32'h40800000, 32'h40a00000);   // (4,5)
        mem[2] = vtx(32'h40c00000, 32'h40e00000);   // (6,7)
        plan_frame(3, drops);
        s_mvp = n_mvp; s_fd = n_fd;
        start_frame(1'b0, 3);
        repeat (10) @(posedge clock);
        #1;
        frame_start = 1'b1;
        update_mvp_req = 1'b1;
        num_verts = 9'd2;
        @(posedge clock); #1;
        frame_start = 1'b0;
        update_mvp_req = 1'b0;
        wait_done(400, ok);
        tests_run++;
        if (!ok || xs_q.size() != 2 || n_mvp - s_mvp != 0 || n_fd - s_fd != 1) begin
            tests_failed++;
            $display("FAIL odd_fetch ok=%0d fetched=%0d mvp=%0d frames=%0d want 1,2,0,1",
                     ok, xs_q.size(), n_mvp - s_mvp, n_fd - s_fd);
        end
        if (xs_q.size() == 2) begin
            tests_run++;
            if (xs_q[0] !== mem[0][95:64] || xs_q[1] !== mem[1][95:64]) begin
                tests_failed++;
                $display("FAIL odd_order got=%h,%h want=%h,%h",
                         xs_q[0], xs_q[1], mem[0][95:64], mem[1][95:64]);
            end
        end
        tests_run++;
        if (got_q.size() != exp_q.size() || got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL odd_lines got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL odd_line got=%h want=%h", g, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_single_line();
        test_mvp_only();
        test_short_frame();
        test_clip();
        test_backpressure();
        test_reset_mid();
        test_odd_ignore();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mvp_sequencer.md
MVP_SEQUENCER -- requirements
Module: mvp_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: vertex memory address width.
REQ-002 clock  in  1  rising-edge clock, the block's only clock.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 frame_start  in  1  one-cycle request to render one frame.
REQ-005 update_mvp_req  in  1  sampled with frame_start; 1 = rebuild the MVP matrix first.
REQ-006 num_verts  in  ADDR_W+1  vertex count for the frame, sampled with frame_start.
REQ-007 vert_addr  out  ADDR_W  vertex memory read address.
REQ-008 vert_data  in  96  {x,y,z} IEEE-754 singles, x in [95:64]; valid the cycle after vert_addr.
REQ-009 xf_start, xf_update_mvp  out  1,1  start pulse and mode to the transform unit.
REQ-010 xf_x, xf_y, xf_z  out  32 each  vertex to transform.
REQ-011 xf_done  in  1  transform unit idle; high whenever results are valid.
REQ-012 xf_ox, xf_oy  in  32 each  signed integer screen coordinates.
REQ-013 line_valid  out  1 / line_ready  in  1  line output handshake.
REQ-014 x0, x1  out  10 each; y0, y1  out  9 each  line endpoints.
REQ-015 frame_done  out  1  one-cycle pulse at end of frame.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 drop_count  out  16  lines rejected by clipping this frame.

Function
REQ-018 States: IDLE, MVP_START, MVP_WAIT, FETCH, FETCH_WAIT, XF_START, XF_WAIT, STORE, EMIT, DONE.
REQ-019 IDLE + frame_start: latch num_verts, clear vertex index and drop_count, go MVP_START if update_mvp_req else FETCH.
REQ-020 frame_start while busy is ignored.
REQ-021 MVP_START: xf_start=1, xf_update_mvp=1 for exactly one cycle, then MVP_WAIT.
REQ-022 XF_START: xf_start=1, xf_update_mvp=0 for exactly one cycle, then XF_WAIT.
REQ-023 xf_done is not sampled in the xf_start cycle; it is sampled from the following cycle on.
REQ-024 MVP_WAIT/XF_WAIT exit on the first sampled xf_done=1.
REQ-025 After MVP_WAIT, go FETCH, or DONE when num_verts<2.
REQ-026 FETCH drives vert_addr=index.
REQ-027 FETCH_WAIT registers vert_data into xf_x/y/z.
REQ-028 xf_x/y/z hold constant from XF_START until XF_WAIT exits.
REQ-029 STORE on even index: capture (xf_ox,xf_oy) as P0, index+1, go FETCH.
REQ-030 STORE on odd index: capture P1, index+1, go EMIT if both endpoints visible.
REQ-031 STORE on odd index with an endpoint not visible: increment drop_count, go FETCH, or DONE when index+1 >= num_verts-1.
REQ-032 Visible: 0 <= ox <= 639 and 0 <= oy <= 479, compared as signed 32-bit.
REQ-033 EMIT: line_valid=1, x0/y0/x1/y1 stable until line_ready=1.
REQ-034 On the handshake cycle, go FETCH or DONE by the rule in REQ-031; line_valid drops the next cycle.
REQ-035 Odd num_verts: the last vertex is never fetched.
REQ-036 num_verts=0 or 1 with no MVP update: FETCH is skipped and the block goes straight to DONE.
REQ-037 DONE: frame_done=1 for one cycle, then IDLE.
REQ-038 drop_count saturates at 16'hFFFF and holds until the next accepted frame_start.
REQ-039 Latency with no MVP update: frame_start sampled at edge T gives xf_start high in cycle T+3.

Reset
REQ-040 resetn=0 at a clock edge forces IDLE from any state, including mid-transform and mid-EMIT.
REQ-041 On reset: xf_start=0, xf_update_mvp=0, line_valid=0, frame_done=0, busy=0, drop_count=0, vert_addr=0, xf_x/y/z=0, x0/y0/x1/y1=0.
REQ-042 Reset does not wait for xf_done.

Structure
REQ-043 gfx_pkg holds SCREEN_W=640, SCREEN_H=480, FLOAT_ONE=32'h3f800000 and the state enum.
REQ-044 One sub-module, screen_clip (combinational visibility test of one point), instantiated twice.

Verification
REQ-045 Bench model of the transform unit: xf_done drops the cycle after xf_start, rises 20 cycles later, with ox=int(x)+320 and oy=int(y)+240.
REQ-046 num_verts=2, vertices (0,0,0),(10,5,0), no MVP -> one line (320,240)->(330,245), frame_done, drop_count=0.
REQ-047 update_mvp_req=1, num_verts=0 -> exactly one xf_start with xf_update_mvp=1, then frame_done, no line_valid.
REQ-048 num_verts=4, second vertex x=400.0 (ox=720) -> exactly one line output (vertices 2,3), drop_count=1.
REQ-049 line_ready held low 50 cycles -> line_valid and endpoints stable throughout; exactly one transfer on release.
REQ-050 resetn low during XF_WAIT -> IDLE next cycle, all outputs at REQ-041 values; a new frame_start then completes normally.
REQ-051 num_verts=3 -> only vertices 0,1 fetched; frame_start pulsed mid-frame -> ignored.
